// File: rtl/p_if.sv
`default_nettype none
// ============================================================================
// Module   : p_if
// Purpose  : Byte-serial instruction fetch unit. Assembles little-endian
//            32-bit words from an 8-bit memory port and holds them for decode.
//            Optional macro ICACHE_EN adds a 64-entry direct-mapped I-cache.
// Revision : 1.0  initial release
// ============================================================================
module p_if (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic [31:0] mem_a,
    input  logic        stall_in,
    input  logic        jump_in,
    input  logic [31:0] jump_addr_in,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] c_word_step  = 32'd4;
    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;
    logic [1:0]  r_idx;
    logic [1:0]  r_pidx;
    logic        r_pend;

    logic        w_fetching;
    logic        w_req;
    logic        w_accept;
    logic        w_hit;
    logic [31:0] w_hit_word;

    assign w_accept = r_inst_valid & ~stall_in;
    assign w_req    = w_fetching & mem_grant;

    assign mem_rd     = w_fetching & rdy_in & rst_in;
    assign mem_a      = r_pc + {30'd0, r_idx};
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

`ifdef ICACHE_EN
    logic [63:0] r_cv;
    logic [23:0] r_ctag  [64];
    logic [31:0] r_cdata [64];
    logic [5:0]  w_cidx;
    logic        w_fill;

    assign w_cidx     = r_pc[7:2];
    assign w_hit      = (r_state == S_FETCH) && (r_idx == 2'd0) && r_cv[w_cidx]
                        && (r_ctag[w_cidx] == r_pc[31:8]);
    assign w_hit_word = r_cdata[w_cidx];
    // Fill with the completed word as the last byte lands; a jump drops it.
    assign w_fill     = (r_state == S_DRAIN) && r_pend && !jump_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_cv <= '0;
        end else if (rdy_in && w_fill) begin
            r_cv[w_cidx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && w_fill) begin
            r_ctag[w_cidx]  <= r_pc[31:8];
            r_cdata[w_cidx] <= {mem_din, r_inst[23:0]};
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_word = 32'd0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fetching  = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (w_hit) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_fetching = 1'b1;
                    if (mem_grant && (r_idx == 2'd3)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: if (r_pend)   w_state_nxt = S_HOLD;
            S_HOLD:  if (w_accept) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
        if (jump_in) begin
            w_state_nxt = S_FETCH;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_FETCH;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_pc         <= 32'd0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
            r_idx        <= 2'd0;
            r_pidx       <= 2'd0;
            r_pend       <= 1'b0;
        end else if (rdy_in) begin
            if (jump_in) begin
                r_pc         <= jump_addr_in & c_align_mask;
                r_idx        <= 2'd0;
                r_pend       <= 1'b0;
                r_inst_valid <= 1'b0;
            end else begin
                r_pend <= w_req;
                r_pidx <= r_idx;
                // idx wraps 3 -> 0 as the fetch moves into DRAIN
                if (w_req) begin
                    r_idx <= r_idx + 2'd1;
                end
                if (r_pend) begin
                    r_inst[{r_pidx, 3'b000} +: 8] <= mem_din;
                end
                if ((r_state == S_DRAIN) && r_pend) begin
                    r_inst_valid <= 1'b1;
                    r_inst_pc    <= r_pc;
                end
                if (w_hit) begin
                    r_inst       <= w_hit_word;
                    r_inst_valid <= 1'b1;
                    r_inst_pc    <= r_pc;
                end
                if (w_accept) begin
                    r_pc         <= r_pc + c_word_step;
                    r_inst_valid <= 1'b0;
                    r_idx        <= 2'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_p_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_if
// Purpose  : Self-checking bench for p_if: directed scenarios plus random
//            traffic against a transaction-level fetch model.
// Revision : 1.0  initial release
// ============================================================================
module tb_p_if;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic        mem_grant = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic        mem_rd;
    logic [31:0] mem_a;
    logic        stall_in = 1'b0;
    logic        jump_in = 1'b0;
    logic [31:0] jump_addr_in = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    p_if dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .mem_grant    (mem_grant),
        .mem_din      (mem_din),
        .mem_rd       (mem_rd),
        .mem_a        (mem_a),
        .stall_in     (stall_in),
        .jump_in      (jump_in),
        .jump_addr_in (jump_addr_in),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Memory contents: a fixed function of the address, 0x00000013 at 0.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Model: fetch progress as counts of bytes requested/received for m_pc.
    bit          m_known = 1'b0;
    logic [31:0] m_pc = 32'd0;
    int          m_issued = 0;
    int          m_got = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_word = 32'd0;
    logic [31:0] m_inst_pc = 32'd0;
    bit          m_flight = 1'b0;
    int          m_fidx = 0;
    logic [7:0]  m_din_next = 8'd0;
`ifdef ICACHE_EN
    bit          m_cv [64];
    logic [23:0] m_ctag [64];
    logic [31:0] m_cdata [64];
`endif

    function automatic bit model_hit();
`ifdef ICACHE_EN
        return !m_valid && (m_issued == 0) && m_cv[m_pc[7:2]] && (m_ctag[m_pc[7:2]] == m_pc[31:8]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_rd();
        return rst_in && rdy_in && !m_valid && (m_issued < 4) && !model_hit();
    endfunction

    task automatic model_check();
        if (m_known) begin
            chk("mem_rd", {31'd0, mem_rd}, {31'd0, exp_rd()});
            if (exp_rd()) chk("mem_a", mem_a, m_pc + 32'(m_issued));
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("inst", inst, m_word);
                chk("inst_pc", inst_pc, m_inst_pc);
            end
        end
    endtask

    task automatic model_edge();
        bit granted;
        if (!rst_in) begin
            m_known = 1'b1; m_pc = 32'd0; m_issued = 0; m_got = 0; m_valid = 1'b0;
            m_word = 32'd0; m_inst_pc = 32'd0; m_flight = 1'b0;
            m_din_next = 8'($urandom);
`ifdef ICACHE_EN
            for (int i = 0; i < 64; i++) m_cv[i] = 1'b0;
`endif
        end else if (rdy_in) begin
            granted = exp_rd() && mem_grant;
            m_din_next = granted ? mem_byte(m_pc + 32'(m_issued)) : 8'($urandom);
            if (jump_in) begin
                m_pc = jump_addr_in & 32'hFFFF_FFFC;
                m_issued = 0; m_got = 0; m_flight = 1'b0; m_valid = 1'b0;
            end else if (m_valid) begin
                if (!stall_in) begin
                    m_pc = m_pc + 32'd4;
                    m_valid = 1'b0; m_issued = 0; m_got = 0;
                end
            end else if (model_hit()) begin
`ifdef ICACHE_EN
                m_word = m_cdata[m_pc[7:2]];
`endif
                m_valid = 1'b1; m_inst_pc = m_pc;
            end else begin
                if (m_flight) begin
                    m_word[8*m_fidx +: 8] = mem_din;
                    m_got++;
                end
                m_flight = granted;
                m_fidx = m_issued;
                if (granted) m_issued++;
                if (m_got == 4) begin
                    m_valid = 1'b1; m_inst_pc = m_pc;
`ifdef ICACHE_EN
                    m_cv[m_pc[7:2]] = 1'b1;
                    m_ctag[m_pc[7:2]] = m_pc[31:8];
                    m_cdata[m_pc[7:2]] = m_word;
`endif
                end
            end
        end
        // rdy_in low: memory keeps mem_din and nothing in the model moves
    endtask

    task automatic step(input logic rst, input logic rdy, input logic grant, input logic stall,
                        input logic jump, input logic [31:0] ja);
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy; mem_grant = grant; stall_in = stall;
        jump_in = jump; jump_addr_in = ja; mem_din = m_din_next;
        #1;
        model_check();
        model_edge();
    endtask

    initial begin
        logic [31:0] ja;
        int sel;

        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 32'h55);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);

        // Back-to-back bytes from 0, word valid five cycles later
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 1, 0, 0);
            chk("seq_a", mem_a, 32'(i));
        end
        step(1, 1, 1, 1, 0, 0);
        chk("drain_rd", {31'd0, mem_rd}, 32'd0);
        step(1, 1, 1, 1, 0, 0);
        chk("lat5_valid", {31'd0, inst_valid}, 32'd1);
        chk("inst_13", inst, 32'h0000_0013);

        // Held under stall, then accepted
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1, 1, 0, 0);
            chk("stall_inst", inst, 32'h0000_0013);
        end
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("next_pc4", mem_a, 32'd4);

        // Grant lost at byte 2
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        chk("drop_a", mem_a, 32'd6);
        step(1, 1, 1, 1, 0, 0);
        chk("reissue_a", mem_a, 32'd6);
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("drop_valid", {31'd0, inst_valid}, 32'd1);
        chk("drop_word", inst, mem_word(32'd4));

        // Jump with byte 1 of pc 8 in flight
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 1, 32'h0000_1006);
        step(1, 1, 1, 1, 0, 0);
        chk("jump_a", mem_a, 32'h0000_1004);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0, 0);
        chk("jump_word", inst, mem_word(32'h0000_1004));
        chk("jump_pc", inst_pc, 32'h0000_1004);

        // Wrap from the top of the address space
        step(1, 1, 1, 1, 1, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0, 0);
        chk("top_pc", inst_pc, 32'hFFFF_FFFC);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("wrap_a", mem_a, 32'd0);

`ifdef ICACHE_EN
        step(1, 1, 1, 1, 1, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 1, 32'h0000_0100);
        step(1, 1, 1, 1, 0, 0);
        chk("hit_no_rd", {31'd0, mem_rd}, 32'd0);
        step(1, 1, 1, 1, 0, 0);
        chk("hit_valid", {31'd0, inst_valid}, 32'd1);
        chk("hit_word", inst, mem_word(32'h0000_0100));
`endif

        for (int n = 0; n < 4000; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40)      ja = 32'h0000_0100 + 32'($urandom_range(0, 63));
            else if (sel < 55) ja = 32'h0000_4100 + 32'($urandom_range(0, 63));
            else if (sel < 75) ja = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else               ja = $urandom;
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 29) == 0), ja);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/p_if.md
P_IF -- requirements
Module: p_if

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 clk_in  input  1  clock; all state changes on rising edge.
REQ-003 rst_in  input  1  synchronous active-low reset.
REQ-004 rdy_in  input  1  global enable; low freezes all state.
REQ-005 mem_grant  input  1  memory port granted to fetch this cycle.
REQ-006 mem_din  input  8  read byte, valid one cycle after a granted request.
REQ-007 mem_rd  output  1  byte read request.
REQ-008 mem_a  output  32  byte address of the request.
REQ-009 stall_in  input  1  decode busy; fetched word is not consumed.
REQ-010 jump_in  input  1  redirect from decode.
REQ-011 jump_addr_in  input  32  redirect target.
REQ-012 inst_valid  output  1  inst/inst_pc hold a complete instruction.
REQ-013 inst  output  32  instruction word, little-endian.
REQ-014 inst_pc  output  32  address of inst.

Function
REQ-015 SHALL hold a registered pc, the fetch address of the word in progress.
REQ-016 SHALL use states FETCH (issue bytes 0-3), DRAIN (capture last byte) and HOLD (inst_valid=1).
REQ-017 In FETCH, SHALL drive mem_rd=1 and mem_a=pc+idx (idx 0..3); idx SHALL advance only in a cycle with mem_grant=1.
REQ-018 SHALL register pend<=mem_rd&mem_grant and pidx<=idx, and SHALL write mem_din into inst byte pidx when pend=1.
REQ-019 After idx 3 is granted, SHALL enter DRAIN; after that byte is captured, SHALL enter HOLD with inst_valid=1 and inst_pc=pc.
REQ-020 Minimum latency from entering FETCH to inst_valid=1 SHALL be 5 cycles with continuous grant; each ungranted cycle SHALL add one cycle.
REQ-021 Accept is inst_valid&!stall_in; on accept, SHALL set pc<=pc+4, inst_valid<=0, idx<=0, state<=FETCH.
REQ-022 With stall_in=1 in HOLD, inst and inst_pc SHALL stay stable.
REQ-023 jump_in=1 SHALL take priority over accept and fetch in any state: pc<={jump_addr_in[31:2],2'b00}, idx<=0, pend<=0, inst_valid<=0, state<=FETCH.
REQ-024 A byte in flight during a jump SHALL be discarded, not captured.
REQ-025 pc+4 SHALL wrap modulo 2^32; from 0xFFFFFFFC it SHALL go to 0x00000000.
REQ-026 mem_rd SHALL be 0 in DRAIN and HOLD, and whenever rdy_in=0.
REQ-027 With rdy_in=0, SHALL update no register; mem_din SHALL be held by the memory system until rdy_in returns.

Reset
REQ-028 When rst_in=0 at a clock edge, SHALL set pc=0, inst=0, inst_pc=0, inst_valid=0, mem_rd=0, mem_a=0, idx=0, pend=0 and state=FETCH, overriding rdy_in, jump_in and any fetch in progress.
REQ-029 The first request after reset release SHALL be to mem_a=0x00000000.

Configuration
REQ-030 Macro ICACHE_EN: when defined, SHALL add a 64-entry direct-mapped instruction cache (index pc[7:2], tag pc[31:8], one valid bit per entry).
REQ-031 With ICACHE_EN, a hit on entering FETCH SHALL go to HOLD on the next cycle with the cached word and issue no memory request; a miss SHALL fetch as in REQ-017..019 and write the entry on entering HOLD.
REQ-032 With ICACHE_EN, reset SHALL clear all valid bits; a jump SHALL NOT invalidate entries.
REQ-033 Without ICACHE_EN, SHALL use no cache storage and every fetch SHALL follow REQ-017..019.

Verification
REQ-034 Reset, grant=1, memory holds 0x00000013 at address 0 -> mem_a 0,1,2,3 on consecutive cycles; inst_valid=1 on cycle 5 with inst=0x00000013 and inst_pc=0.
REQ-035 Grant dropped one cycle at idx 2 -> address 2 reissued; inst_valid=1 one cycle later; word correct.
REQ-036 stall_in=1 for 3 cycles in HOLD -> inst/inst_pc stable and mem_rd=0; release -> next request at pc=4.
REQ-037 jump_in=1, jump_addr_in=0x00001006 while idx=2 with a byte in flight -> next request at 0x00001004; the in-flight byte never appears in inst.
REQ-038 pc=0xFFFFFFFC accepted -> next request at 0x00000000.
REQ-039 ICACHE_EN, loop jumping back to 0x100 -> second fetch of 0x100 has inst_valid one cycle after FETCH and mem_rd=0.
